fetch_queue: RTL and testbench

Parametrised instruction-fetch front end: owns the fetch PC, drives the instruction bus, and buffers returned instructions with their PCs in a DEPTH-entry FIFO for decode. It sits between the ibus and the IF/decode stage of the pipelined core. A redirect from EXE (taken branch or jump) flushes the queue and restarts fetch; an in-flight bus request is completed and its data discarded. Decode consumes entries through a valid/ready handshake, so a stalled pipeline no longer re-requests the same PC.

---
 rtl/fetch_queue_pkg.sv | 30 +++
 rtl/fetch_queue_fifo.sv | 66 ++++++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: bus payloads, queue entry, reset PC.
package fetch_queue_pkg;

    localparam int unsigned FQ_XLEN = 64;
    localparam int unsigned ILEN    = 32;

    localparam logic [FQ_XLEN-1:0] PCINIT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic               valid;
        logic [FQ_XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [ILEN-1:0]    inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_REQ  = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_e;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched entries with push/pop/flush and an occupancy count.
module fetch_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives ibus, queues {pc, inst} for decode.
// Optional FETCHQ_BYPASS_EN: an empty queue hands a returning instruction straight to decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH   = 4,
    parameter int unsigned     XLEN    = 64,
    parameter logic [XLEN-1:0] INIT_PC = XLEN'(PCINIT)
) (
    input  logic                         clk,
    input  logic                         reset,
    output ibus_req_t                    ireq,
    input  ibus_resp_t                   iresp,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [XLEN-1:0]              deq_pc,
    output logic [ILEN-1:0]              deq_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = $bits(fetch_entry_t);

    fq_state_e       state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   head_raw;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            fifo_empty;
    logic            data_ok;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after;
    logic            room;

    assign head       = fetch_entry_t'(head_raw);
    assign fifo_empty = (fifo_count == '0);
    assign data_ok    = iresp.data_ok;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = (state_q == FQ_REQ) & data_ok & ~redirect_valid & deq_ready & fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push            = (state_q == FQ_REQ) & data_ok & ~redirect_valid & ~bypass;
    assign pop             = ~redirect_valid & ~fifo_empty & deq_ready;
    assign push_entry.pc   = FQ_XLEN'(req_addr_q);
    assign push_entry.inst = iresp.data;

    // Slot check uses the occupancy after this cycle's enqueue/dequeue.
    assign count_after = fifo_count + CW'(push) - CW'(pop);
    assign room        = (count_after < CW'(DEPTH));

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (EW'(push_entry)),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_raw),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FQ_IDLE;
            fetch_pc_q <= INIT_PC;
            req_addr_q <= INIT_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next state and PC bookkeeping; an issued request is always carried to data_ok.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            FQ_IDLE: begin
                if (redirect_valid) begin
                    state_d    = FQ_REQ;
                    fetch_pc_d = redirect_pc;
                    req_addr_d = redirect_pc;
                end else if (room) begin
                    state_d    = FQ_REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            FQ_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    if (data_ok) begin
                        req_addr_d = redirect_pc;
                    end else begin
                        state_d = FQ_DROP;
                    end
                end else if (data_ok) begin
                    fetch_pc_d = req_addr_q + XLEN'(4);
                    if (room) begin
                        req_addr_d = req_addr_q + XLEN'(4);
                    end else begin
                        state_d = FQ_IDLE;
                    end
                end
            end
            FQ_DROP: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end
                if (data_ok) begin
                    state_d    = FQ_REQ;
                    req_addr_d = redirect_valid ? redirect_pc : fetch_pc_q;
                end
            end
            default: begin
                state_d = FQ_IDLE;
            end
        endcase
    end

    always_comb begin
        ireq       = '0;
        ireq.valid = (state_q != FQ_IDLE);
        ireq.addr  = FQ_XLEN'(req_addr_q);
        deq_valid  = (~fifo_empty | bypass) & ~redirect_valid;
        deq_pc     = bypass ? req_addr_q : XLEN'(head.pc);
        deq_inst   = bypass ? iresp.data : head.inst;
    end

    assign count = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-configurable ibus model and an expected-entry queue.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned CW    = $clog2(DEPTH+1);
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    ibus_req_t       ireq;
    ibus_resp_t      iresp;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_pc;
    logic [31:0]     deq_inst;
    logic [CW-1:0]   count;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_pc         (deq_pc),
        .deq_inst       (deq_inst),
        .count          (count)
    );

    always #5 clk = ~clk;

    int              n_assert = 0;
    int              n_fail   = 0;
    int              n_deq    = 0;
    fetch_entry_t    sb[$];
    bit              pend;
    bit              drop_pending;
    int              left;
    int              bus_lat;
    logic [63:0]     pend_addr;
    logic [63:0]     next_addr;
    logic            last_deq_valid;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return (a[31:0] * 32'd3) ^ 32'h5A5A_0F0F ^ a[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive bus/redirect at negedge, check combinational outputs, advance past posedge.
    task automatic step(input logic rv, input logic [63:0] rpc);
        bit           data_ok;
        bit           accepted;
        bit           bypass_hit;
        bit           exp_valid;
        fetch_entry_t e;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        data_ok        = 1'b0;
        if (ireq.valid) begin
            if (!pend) begin
                chk("req_addr", ireq.addr, next_addr);
                pend      = 1'b1;
                pend_addr = next_addr;
                left      = bus_lat;
            end else begin
                chk("addr_hold", ireq.addr, pend_addr);
            end
            if (left == 1) data_ok = 1'b1;
            else left--;
        end
        iresp.data_ok = data_ok;
        iresp.data    = data_ok ? inst_of(ireq.addr) : 32'hDEAD_BEEF;
        #1;
        chk("count", 64'(count), 64'(sb.size()));
        accepted   = data_ok && !rv && !drop_pending;
        bypass_hit = BYP && accepted && deq_ready && (sb.size() == 0);
        exp_valid  = !rv && ((sb.size() != 0) || bypass_hit);
        last_deq_valid = deq_valid;
        chk("deq_valid", 64'(deq_valid), 64'(exp_valid));
        if (exp_valid && deq_ready) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
            end else begin
                e.pc   = pend_addr;
                e.inst = inst_of(pend_addr);
            end
            chk("deq_pc", deq_pc, e.pc);
            chk("deq_inst", 64'(deq_inst), 64'(e.inst));
            n_deq++;
        end
        if (accepted && !bypass_hit) begin
            e.pc   = pend_addr;
            e.inst = inst_of(pend_addr);
            sb.push_back(e);
        end
        if (data_ok) begin
            pend = 1'b0;
            if (accepted) next_addr = pend_addr + 64'd4;
            drop_pending = 1'b0;
        end
        if (rv) begin
            sb.delete();
            next_addr = rpc;
            if (pend) drop_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        iresp          = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        iresp          = '0;
        pend           = 1'b0;
        drop_pending   = 1'b0;
        left           = 0;
        bus_lat        = 1;
        pend_addr      = '0;
        next_addr      = PCINIT;

        // Reset values
        #12;
        chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
        chk("rst_ireq_addr", ireq.addr, PCINIT);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_pc", deq_pc, 64'd0);
        chk("rst_deq_inst", 64'(deq_inst), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req_valid", 64'(ireq.valid), 64'd1);

        // Streaming: data_ok every cycle, decode always ready
        deq_ready = 1'b1;
        n_deq     = 0;
        repeat (12) step(1'b0, '0);
        chk("stream_deq_count", 64'(n_deq), BYP ? 64'd12 : 64'd11);

        // Decode stalled: queue fills to DEPTH then fetch idles
        deq_ready = 1'b0;
        step(1'b1, 64'h8000_0000);
        repeat (10) step(1'b0, '0);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_idle", 64'(ireq.valid), 64'd0);
        deq_ready = 1'b1;
        step(1'b0, '0);
        deq_ready = 1'b0;
        chk("refill_req", 64'(ireq.valid), 64'd1);
        repeat (5) step(1'b0, '0);
        chk("refull_count", 64'(count), 64'(DEPTH));
        chk("refull_idle", 64'(ireq.valid), 64'd0);

        // Redirect while a slow request is outstanding
        bus_lat   = 3;
        deq_ready = 1'b1;
        step(1'b1, 64'h8000_0010);
        step(1'b0, '0);
        chk("slow_pend_addr", pend_addr, 64'h8000_0010);
        step(1'b1, 64'h8000_1000);
        chk("redirect_flush_count", 64'(count), 64'd0);
        repeat (10) step(1'b0, '0);

        // Redirect coinciding with data_ok
        bus_lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (ireq.valid && (!pend || left == 1)) ok = 1'b1;
            else step(1'b0, '0);
        end
        chk("sync_data_ok", 64'(ok), 64'd1);
        step(1'b1, 64'h8000_2000);
        chk("same_cycle_redirect_valid", 64'(last_deq_valid), 64'd0);
        chk("same_cycle_redirect_addr", ireq.addr, 64'h8000_2000);
        repeat (6) step(1'b0, '0);

        // Steady state at count=2 with enqueue and dequeue every cycle
        deq_ready = 1'b0;
        step(1'b1, 64'h8000_3000);
        for (int i = 0; i < 10 && count < 2; i++) step(1'b0, '0);
        chk("steady_start", 64'(count), 64'd2);
        deq_ready = 1'b1;
        n_deq     = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0);
            chk("steady_count", 64'(count), 64'd2);
        end
        chk("steady_deq", 64'(n_deq), 64'd20);

        // Empty queue, data_ok with decode ready: same-cycle hand-off only with bypass
        step(1'b1, 64'h8000_4000);
        step(1'b0, '0);
        chk("empty_first_deq_valid", 64'(last_deq_valid), 64'(BYP));
        repeat (4) step(1'b0, '0);

        // Reset asserted mid-request drops the bus request immediately
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_ireq_valid", 64'(ireq.valid), 64'd0);
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_addr", ireq.addr, PCINIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
